// File: rtl/logicunit_pkg.sv
// rtl/logicunit_pkg.sv - shared encodings and bit-level logic function for the logic-unit arbiter
package logicunit_pkg;

    localparam logic [1:0] LU_AND = 2'd0;
    localparam logic [1:0] LU_OR  = 2'd1;
    localparam logic [1:0] LU_NOR = 2'd2;
    localparam logic [1:0] LU_XOR = 2'd3;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_t;

    // Behaviour of the original single-bit logic unit; the wide unit replicates it per bit.
    function automatic logic lu_bit(input logic a, input logic b, input logic [1:0] control);
        logic r;
        case (control)
            LU_AND:  r = a & b;
            LU_OR:   r = a | b;
            LU_NOR:  r = ~(a | b);
            default: r = a ^ b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logicunit_arbiter_if.sv
// rtl/logicunit_arbiter_if.sv - two request ports and one response port of the logic-unit arbiter
interface logicunit_arbiter_if #(parameter int WIDTH = 32);

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_A;
    logic [WIDTH-1:0] req0_B;
    logic [1:0]       req0_control;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_A;
    logic [WIDTH-1:0] req1_B;
    logic [1:0]       req1_control;

    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_out;
    logic             resp_id;

    modport slave (
        input  req0_valid, req0_A, req0_B, req0_control,
        output req0_ready,
        input  req1_valid, req1_A, req1_B, req1_control,
        output req1_ready,
        output resp_valid, resp_out, resp_id,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_A, req0_B, req0_control,
        input  req0_ready,
        output req1_valid, req1_A, req1_B, req1_control,
        input  req1_ready,
        input  resp_valid, resp_out, resp_id,
        output resp_ready
    );

endinterface

// File: rtl/logicunit_w.sv
// rtl/logicunit_w.sv - WIDTH-bit combinational logic unit built from the 1-bit unit per bit
module logicunit_w
    import logicunit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       control,
    output logic [WIDTH-1:0] out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign out[i] = lu_bit(a[i], b[i], control);
    end

endmodule

// File: rtl/logicunit_arbiter.sv
// rtl/logicunit_arbiter.sv - round-robin share of one logic unit between two requesters,
// single-entry registered response
module logicunit_arbiter
    import logicunit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    logicunit_arbiter_if.slave   bus
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             last_grant;
    logic             can_accept;
    logic             grant_valid;
    logic             grant_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_ctl;
    logic [WIDTH-1:0] lu_out;

    // Gating with reset keeps both readies low while reset is held and on its release edge.
    always_comb begin
        can_accept  = reset && ((state == ARB_EMPTY) || bus.resp_ready);
        grant_valid = can_accept && (bus.req0_valid || bus.req1_valid);
        grant_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end

        state_nxt = state;
        if (grant_valid) begin
            state_nxt = ARB_FULL;
        end else if ((state == ARB_FULL) && bus.resp_ready) begin
            state_nxt = ARB_EMPTY;
        end
    end

    assign bus.req0_ready = grant_valid && !grant_id;
    assign bus.req1_ready = grant_valid && grant_id;
    assign bus.resp_valid = (state == ARB_FULL);

    assign op_a   = grant_id ? bus.req1_A       : bus.req0_A;
    assign op_b   = grant_id ? bus.req1_B       : bus.req0_B;
    assign op_ctl = grant_id ? bus.req1_control : bus.req0_control;

    logicunit_w #(.WIDTH(WIDTH)) u_lu (
        .a       (op_a),
        .b       (op_b),
        .control (op_ctl),
        .out     (lu_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARB_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first conflict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.resp_out <= '0;
            bus.resp_id  <= 1'b0;
            last_grant   <= 1'b1;
        end else if (grant_valid) begin
            bus.resp_out <= lu_out;
            bus.resp_id  <= grant_id;
            last_grant   <= grant_id;
        end
    end

endmodule

// File: doc/logicunit_arbiter.md
# logicunit_arbiter

Shares one WIDTH-bit logic unit (AND/OR/NOR/XOR) between two requesters. Each requester presents operands and a 2-bit control on a valid/ready port. The arbiter grants one request per cycle using round-robin priority, registers the result with the winner's ID, and holds it on a single-entry valid/ready response port until it is consumed. It sits between the two operand sources in the datapath and the shared logic unit.

## Interface
- `WIDTH`, 32, operand and result width in bits.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. Asserted (0) clears all state immediately.
- `req0_valid` input 1: requester 0 has an operation pending.
- `req0_ready` output 1: requester 0's operation is accepted this cycle.
- `req0_A`, `req0_B` input WIDTH: requester 0 operands.
- `req0_control` input 2: requester 0 operation select.
- `req1_valid`, `req1_ready`, `req1_A`, `req1_B`, `req1_control`: same as requester 0, for requester 1.
- `resp_valid` output 1: result register holds an unconsumed result.
- `resp_ready` input 1: consumer accepts the result this cycle.
- `resp_out` output WIDTH: registered result.
- `resp_id` output 1: index of the requester that produced `resp_out`.

## Operation
- Control encoding: 0 = AND, 1 = OR, 2 = NOR, 3 = XOR, applied bitwise over WIDTH bits. No carry, so no width growth.
- Two states.
  - EMPTY: `resp_valid`=0.
  - FULL: `resp_valid`=1.
- `can_accept` = EMPTY, or (FULL and `resp_ready`=1). The second case is drain-and-refill in the same cycle.
- Grant rule, evaluated only when `can_accept`=1:
  - Only one requester valid: grant it.
  - Both valid: grant the requester not granted most recently (`last_grant` register).
  - Neither valid: no grant.
- `reqN_ready` = `can_accept` AND (grant == N). This is combinational and may depend on `reqN_valid`. Exactly one, or zero, readies are high per cycle.
- On a grant at a clock edge:
  - `resp_out` loads the logic-unit result of the winner's operands.
  - `resp_id` loads the winner's index.
  - `last_grant` loads the winner's index.
  - State becomes FULL.
- FULL with `resp_ready`=1 and no grant: state becomes EMPTY. `resp_out` and `resp_id` keep their last values.
- FULL with `resp_ready`=0: `resp_out` and `resp_id` are stable, and both readies are 0.
- A requester may not drop `valid` or change operands/control while `valid`=1 and `ready`=0. The arbiter does not check this.
- Fairness: with both requesters continuously valid and the consumer always ready, grants strictly alternate.

## Timing
- Reset values:
  - state EMPTY, `resp_valid`=0, `resp_out`=0, `resp_id`=0.
  - `last_grant`=1, so requester 0 wins the first conflict.
  - `req0_ready`=`req1_ready`=0 while `reset`=0.
- Latency: a request accepted at edge N appears on `resp_valid`/`resp_out` immediately after edge N.
- Throughput: one operation per cycle while `resp_ready` is held high.
- Reset asserted mid-operation: any pending result is discarded and `resp_valid` falls asynchronously. No accept occurs on the edge that coincides with the reset release.
- Simultaneous accept and drain: the old result is consumed and the new result is loaded at the same edge. `resp_valid` stays 1 with no bubble.

## Structure
- Shared package `logicunit_pkg`:
  - Control encoding constants: `LU_AND`=2'd0, `LU_OR`=2'd1, `LU_NOR`=2'd2, `LU_XOR`=2'd3.
  - State encoding: `ARB_EMPTY`, `ARB_FULL`.
- One sub-module, `logicunit_w`: parameterised WIDTH-wide combinational logic unit (A, B, control → out). It is built from, and bit-identical to, the existing 1-bit logic unit per bit. It is instantiated once, fed by a 2:1 operand/control mux selected by the grant.
- Arbitration, FSM and output register live in `logicunit_arbiter`.

## Test plan
- Reset: hold `reset`=0 with both requesters valid → `resp_valid`=0, `resp_out`=0, both readies 0. Release reset → first grant is to requester 0.
- Single op: req0 valid, A=32'hF0F0_00FF, B=32'h0FF0_0F0F, control=3 → `req0_ready`=1 for 1 cycle. Next cycle: `resp_valid`=1, `resp_out`=32'hFF00_0FF0, `resp_id`=0.
- All encodings: A=32'hAAAA_5555, B=32'hFFFF_0000 on req1 with controls 0–3 → `resp_out` = 32'hAAAA_0000, 32'hFFFF_5555, 32'h0000_AAAA, 32'h5555_5555 respectively; `resp_id`=1 for each.
- Round-robin: both valid for 6 cycles, `resp_ready`=1 → `resp_id` sequence 0,1,0,1,0,1 with `resp_valid` continuously 1.
- Back-pressure: `resp_ready`=0 for 4 cycles while FULL → both readies 0 and `resp_out`/`resp_id` stable. Raise `resp_ready` → drain and refill in the same cycle, with no bubble.
- Reset mid-operation: `reset`=0 asserted between edges while FULL → `resp_valid` drops before the next edge. After release, `last_grant` is back to 1: with both valid, req0 wins.
